freq_cache_v2: RTL

//  Parametrised stream/hash-occurrence cache for the data-frequency extraction pipeline.

---
 rtl/freq_cache_v2.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/freq_cache_v2.sv
// Stream segment plus hash/occurrence table with an internal 2-stage counting pipe
// and a valid/ready drain that emits every stream word followed by every hash entry.
module freq_cache_v2 #(
   parameter int DATA_WIDTH   = 32,
   parameter int OCC_WIDTH    = 16,
   parameter int LENGTH_ARRAY = 100,
   parameter int BIT_ON_TAILS = 7,
   localparam int AW  = $clog2(LENGTH_ARRAY),
   localparam int HW  = BIT_ON_TAILS,
   localparam int HD  = 1 << BIT_ON_TAILS,
   localparam int OAW = (AW > HW) ? AW : HW,
   localparam int EW  = DATA_WIDTH + OCC_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  init_wr_i,
   input  logic [AW-1:0]         init_addr_i,
   input  logic [DATA_WIDTH-1:0] init_data_i,
   input  logic                  hinit_wr_i,
   input  logic [HW-1:0]         hinit_addr_i,
   input  logic [EW-1:0]         hinit_data_i,
   input  logic [AW-1:0]         rd_idx_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   input  logic                  upd_valid_i,
   output logic                  upd_ready_o,
   input  logic [DATA_WIDTH-1:0] upd_key_i,
   input  logic [HW-1:0]         upd_slot_i,
   output logic                  collision_o,
   output logic                  saturated_o,
   input  logic                  drain_start_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic                  out_sel_o,
   output logic [OAW-1:0]        out_addr_o,
   output logic [EW-1:0]         out_data_o,
   output logic                  drain_done_o
);

   localparam logic [OAW-1:0]       STREAM_LAST = OAW'(LENGTH_ARRAY - 1);
   localparam logic [OAW-1:0]       HASH_LAST   = OAW'(HD - 1);
   localparam logic [OCC_WIDTH-1:0] OCC_MAX     = '1;

   typedef enum logic [2:0] {IDLE, WAIT_PIPE, STREAM, HASH, DONE} state_t;

   logic [DATA_WIDTH-1:0] streamMem [LENGTH_ARRAY];
   logic [EW-1:0]         hashMem   [HD];

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] rdData_q;
   logic                  s1Valid_q, s2Valid_q;
   logic [DATA_WIDTH-1:0] s1Key_q, s2Key_q;
   logic [HW-1:0]         s1Slot_q, s2Slot_q;
   logic [EW-1:0]         s2Entry_q, s1Read;
   logic                  collision_q, saturated_q;
   logic                  s2Write, s2Commit, s2Col, s2Sat;
   logic [EW-1:0]         s2NewEntry;
   logic [DATA_WIDTH-1:0] curKey;
   logic [OCC_WIDTH-1:0]  curOcc;
   logic                  updAccept, pipeEmpty, handshake;
   logic                  outValid_q, outValid_d, outSel_q, outSel_d;
   logic [OAW-1:0]        outAddr_q, outAddr_d, loadAddr;
   logic [EW-1:0]         outData_q, outData_d;
   logic                  loadStream, loadHash;
   logic [DATA_WIDTH-1:0] streamRead;
   logic [EW-1:0]         hashRead;

   assign upd_ready_o  = (state_q == IDLE) & ~drain_start_i;
   assign updAccept    = upd_valid_i & upd_ready_o;
   assign pipeEmpty    = ~s1Valid_q & ~s2Valid_q;
   assign handshake    = outValid_q & out_ready_i;
   assign curKey       = s2Entry_q[EW-1:OCC_WIDTH];
   assign curOcc       = s2Entry_q[OCC_WIDTH-1:0];
   assign s2Commit     = s2Write & ~(hinit_wr_i & (hinit_addr_i == s2Slot_q));
   assign rd_data_o    = rdData_q;
   assign collision_o  = collision_q;
   assign saturated_o  = saturated_q;
   assign out_valid_o  = outValid_q;
   assign out_sel_o    = outSel_q;
   assign out_addr_o   = outAddr_q;
   assign out_data_o   = outData_q;
   assign drain_done_o = (state_q == DONE);

   always_ff @(posedge clk_i) begin
      if (init_wr_i) streamMem[init_addr_i] <= init_data_i;
   end

   // hinit and the S2 write-back never target the same slot here: s2Commit excludes it.
   always_ff @(posedge clk_i) begin
      if (hinit_wr_i) hashMem[hinit_addr_i] <= hinit_data_i;
      if (s2Commit)   hashMem[s2Slot_q]     <= s2NewEntry;
   end

   always_comb begin
      s2Write    = 1'b0;
      s2NewEntry = s2Entry_q;
      s2Col      = 1'b0;
      s2Sat      = 1'b0;
      if (s2Valid_q) begin
         if (curOcc == '0) begin
            s2Write    = 1'b1;
            s2NewEntry = {s2Key_q, OCC_WIDTH'(1)};
         end else if (curKey == s2Key_q) begin
            if (curOcc == OCC_MAX) begin
               s2Sat = 1'b1;
            end else begin
               s2Write    = 1'b1;
               s2NewEntry = {s2Key_q, curOcc + OCC_WIDTH'(1)};
            end
         end else begin
            s2Col = 1'b1;
         end
      end
   end

   // Slot read for S1 sees writes landing on the same edge, hinit taking precedence.
   always_comb begin
      if (hinit_wr_i && (hinit_addr_i == s1Slot_q))   s1Read = hinit_data_i;
      else if (s2Write && (s2Slot_q == s1Slot_q))     s1Read = s2NewEntry;
      else                                            s1Read = hashMem[s1Slot_q];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdData_q    <= '0;
         s1Valid_q   <= 1'b0;
         s1Key_q     <= '0;
         s1Slot_q    <= '0;
         s2Valid_q   <= 1'b0;
         s2Key_q     <= '0;
         s2Slot_q    <= '0;
         s2Entry_q   <= '0;
         collision_q <= 1'b0;
         saturated_q <= 1'b0;
      end else begin
         rdData_q    <= (int'(rd_idx_i) < LENGTH_ARRAY) ? streamMem[rd_idx_i] : '0;
         s1Valid_q   <= updAccept;
         if (updAccept) begin
            s1Key_q  <= upd_key_i;
            s1Slot_q <= upd_slot_i;
         end
         s2Valid_q   <= s1Valid_q;
         if (s1Valid_q) begin
            s2Key_q   <= s1Key_q;
            s2Slot_q  <= s1Slot_q;
            s2Entry_q <= s1Read;
         end
         collision_q <= s2Col;
         saturated_q <= s2Sat;
      end
   end

   assign streamRead = (init_wr_i && (init_addr_i == loadAddr[AW-1:0])) ? init_data_i
                                                                       : streamMem[loadAddr[AW-1:0]];
   assign hashRead   = (hinit_wr_i && (hinit_addr_i == loadAddr[HW-1:0])) ? hinit_data_i
                                                                         : hashMem[loadAddr[HW-1:0]];

   // The next word is fetched on the handshake edge, so out_valid never gaps while ready.
   always_comb begin
      state_d    = state_q;
      outValid_d = outValid_q;
      outSel_d   = outSel_q;
      outAddr_d  = outAddr_q;
      outData_d  = outData_q;
      loadStream = 1'b0;
      loadHash   = 1'b0;
      loadAddr   = '0;
      case (state_q)
         IDLE: begin
            if (drain_start_i) state_d = WAIT_PIPE;
         end
         WAIT_PIPE: begin
            if (pipeEmpty) begin
               loadStream = 1'b1;
               state_d    = STREAM;
            end
         end
         STREAM: begin
            if (handshake) begin
               if (outAddr_q == STREAM_LAST) begin
                  loadHash = 1'b1;
                  state_d  = HASH;
               end else begin
                  loadStream = 1'b1;
                  loadAddr   = outAddr_q + OAW'(1);
               end
            end
         end
         HASH: begin
            if (handshake) begin
               if (outAddr_q == HASH_LAST) begin
                  outValid_d = 1'b0;
                  state_d    = DONE;
               end else begin
                  loadHash = 1'b1;
                  loadAddr = outAddr_q + OAW'(1);
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (loadStream) begin
         outValid_d = 1'b1;
         outSel_d   = 1'b0;
         outAddr_d  = loadAddr;
         outData_d  = {{OCC_WIDTH{1'b0}}, streamRead};
      end
      if (loadHash) begin
         outValid_d = 1'b1;
         outSel_d   = 1'b1;
         outAddr_d  = loadAddr;
         outData_d  = hashRead;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         outValid_q <= 1'b0;
         outSel_q   <= 1'b0;
         outAddr_q  <= '0;
         outData_q  <= '0;
      end else begin
         state_q    <= state_d;
         outValid_q <= outValid_d;
         outSel_q   <= outSel_d;
         outAddr_q  <= outAddr_d;
         outData_q  <= outData_d;
      end
   end

endmodule
